seq_multiplier: RTL and testbench

- Multi-cycle unsigned shift-add multiplier for the datapath.
- Consumes operands from upstream N-bit operand registers.
- Produces a 2N-bit product for a downstream result register, which uses `done` as its load enable.
- One iteration per clock, so a full-width multiply costs no combinational array.

---
 rtl/seq_multiplier_if.sv | 15 +
 rtl/seq_multiplier.sv | 89 ++++++++
 tb/tb_seq_multiplier.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between a requester and seq_multiplier.
// The master drives the request and operands; the slave returns status and product.
interface seq_multiplier_if #(
   parameter int N = 8
);
   logic           start;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           busy;
   logic           done;
   logic [2*N-1:0] P;

   modport master (output start, A, B, input  busy, done, P);
   modport slave  (input  start, A, B, output busy, done, P);
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per clock, N+1 edges from
// acceptance to a one-cycle done pulse, product held until the next completion.
module seq_multiplier #(
   parameter int N = 8
) (
   input  logic            clock,
   input  logic            R,
   seq_multiplier_if.slave bus
);
   localparam int             CW   = $clog2(N);
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;
   logic [CW-1:0]  count;
   logic [2*N-1:0] p;
   logic           busy;
   logic           done;
   logic [2*N-1:0] acc_sum;

   // This iteration's sum, so the final edge can load P with the complete product.
   assign acc_sum = acc + (mplier[0] ? mcand : '0);

   // NOTE: every register here updates with <= so all of them see the
   // pre-edge values of each other, whatever order the statements are written in.
   always_ff @(posedge clock) begin
      if (R) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         p      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  mcand  <= {{N{1'b0}}, bus.A};
                  mplier <= bus.B;
                  acc    <= '0;
                  count  <= '0;
                  state  <= RUN;
                  busy   <= 1'b1;
                  done   <= 1'b0;
               end else begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  done   <= 1'b0;
               end
            end

            RUN: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (count == LAST) begin
                  count <= '0;
                  p     <= acc_sum;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  count <= count + CW'(1);
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.P    = p;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a table of operand/product vectors plus
// hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_seq_multiplier;
   localparam int N   = 8;
   localparam int LAT = N + 1;

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [2*N-1:0] p;
      string          name;
   } vec_t;

   logic clock = 1'b0;
   logic R;
   int   checks   = 0;
   int   failures = 0;

   seq_multiplier_if #(.N(N)) bus ();

   seq_multiplier #(.N(N)) dut (
      .clock (clock),
      .R     (R),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Called just after the accepting edge; edges counts from that edge inclusive.
   task automatic wait_done(input string name, output int edges, output int busy_cycles);
      edges       = 1;
      busy_cycles = 0;
      while (!bus.done && edges < LAT + 10) begin
         if (bus.busy) busy_cycles++;
         tick();
         edges++;
      end
      check({name, "_done_seen"}, 64'(bus.done), 64'd1);
   endtask

   task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] p, input string name);
      int edges, busy_cycles;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(name, edges, busy_cycles);
      check({name, "_latency"}, 64'(edges), 64'(LAT));
      check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(N));
      check({name, "_P"}, 64'(bus.P), 64'(p));
      tick();
      check({name, "_done_low_after"}, 64'(bus.done), 64'd0);
      check({name, "_busy_low_after"}, 64'(bus.busy), 64'd0);
      check({name, "_P_held"}, 64'(bus.P), 64'(p));
   endtask

   initial begin
      vec_t vecs[7];
      int   edges, busy_cycles, done_cnt, busy_cnt;

      vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143,   name: "basic_13x11"};
      vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01,  name: "max_255x255"};
      vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0,     name: "zero_a"};
      vecs[3] = '{a: 8'd1,   b: 8'd0,   p: 16'd0,     name: "zero_b"};
      vecs[4] = '{a: 8'd128, b: 8'd2,   p: 16'd256,   name: "carry_128x2"};
      vecs[5] = '{a: 8'd200, b: 8'd3,   p: 16'd600,   name: "200x3"};
      vecs[6] = '{a: 8'd1,   b: 8'd255, p: 16'd255,   name: "1x255"};

      R         = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      tick();
      tick();
      R = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_P", 64'(bus.P), 64'd0);
         check("idle_busy", 64'(bus.busy), 64'd0);
         check("idle_done", 64'(bus.done), 64'd0);
      end

      foreach (vecs[i]) do_mult(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);

      // start pulse and operand churn mid-run must not disturb the product
      bus.A     = 8'd6;
      bus.B     = 8'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      bus.A     = 8'd9;
      bus.B     = 8'd9;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      edges     = 4;
      while (!bus.done && edges < LAT + 10) begin
         bus.A = N'($urandom);
         bus.B = N'($urandom);
         tick();
         edges++;
      end
      check("ignore_done_seen", 64'(bus.done), 64'd1);
      check("ignore_latency", 64'(edges), 64'(LAT));
      check("ignore_P", 64'(bus.P), 64'd42);
      done_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done) done_cnt++;
         if (bus.busy) busy_cnt++;
      end
      check("ignore_no_second_done", 64'(done_cnt), 64'd0);
      check("ignore_no_second_busy", 64'(busy_cnt), 64'd0);
      check("ignore_P_held", 64'(bus.P), 64'd42);

      // back-to-back with start held through the DONE cycle
      bus.A     = 8'd3;
      bus.B     = 8'd5;
      bus.start = 1'b1;
      tick();
      wait_done("b2b_first", edges, busy_cycles);
      check("b2b_first_latency", 64'(edges), 64'(LAT));
      check("b2b_first_P", 64'(bus.P), 64'd15);
      check("b2b_first_busy_in_done", 64'(bus.busy), 64'd0);
      bus.A = 8'd10;
      bus.B = 8'd20;
      tick();
      bus.start = 1'b0;
      check("b2b_rearm_busy", 64'(bus.busy), 64'd1);
      check("b2b_rearm_done", 64'(bus.done), 64'd0);
      check("b2b_P_held_during_run", 64'(bus.P), 64'd15);
      wait_done("b2b_second", edges, busy_cycles);
      check("b2b_spacing", 64'(edges), 64'(LAT));
      check("b2b_second_busy_cycles", 64'(busy_cycles), 64'(N));
      check("b2b_second_P", 64'(bus.P), 64'd200);
      tick();
      check("b2b_idle_after", 64'(bus.busy), 64'd0);

      // reset in the 4th RUN cycle aborts the operation
      bus.A     = 8'd100;
      bus.B     = 8'd100;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      check("abort_busy_before_reset", 64'(bus.busy), 64'd1);
      R = 1'b1;
      tick();
      R = 1'b0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_P", 64'(bus.P), 64'd0);
      done_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done) done_cnt++;
         if (bus.busy) busy_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_no_busy", 64'(busy_cnt), 64'd0);
      check("abort_P_stays_zero", 64'(bus.P), 64'd0);
      do_mult(8'd2, 8'd3, 16'd6, "after_abort_2x3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
